sum_accum_sat: RTL and testbench
================================

# sum_accum_sat

Downstream consumer of the signed n-bit adder's (N+1)-bit sum. Accepts a stream of signed sums over a valid/ready handshake and accumulates a programmable number of them into one frame. Emits the frame total reduced back to N bits, either saturated or wrapped, with an overflow flag. Sits between the adder and the next N-bit datapath stage, restoring operand width.

## Interface
- N, 8, operand width of the upstream adder; `in_sum` is N+1 bits, `out_data` is N bits
- LEN_W, 4, width of `frame_len`; frames are 1..2^LEN_W-1 samples
- ACC_W (localparam), N+1+LEN_W, accumulator width; cannot overflow for any legal frame
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  `in_sum` valid
- in_ready  output  1  block can accept `in_sum` this cycle
- in_sum  input  N+1  signed sum from the adder
- frame_len  input  LEN_W  samples per frame; sampled on the first accept of each frame; 0 treated as 1
- out_valid  output  1  `out_data`/`out_ovf` valid
- out_ready  input  1  downstream accepts result
- out_data  output  N  signed frame result
- out_ovf  output  1  frame total outside [-2^(N-1), 2^(N-1)-1]
- busy  output  1  high in ACCUM or OUT

## Operation
- FSM states: IDLE, ACCUM, OUT.
- IDLE: `in_ready`=1. On accept (`in_valid & in_ready`): acc <= sext(in_sum), cnt <= 1, len_q <= max(frame_len,1). Go OUT if len_q==1, else ACCUM.
- ACCUM: `in_ready`=1. On accept: acc <= acc + sext(in_sum), cnt <= cnt+1; go OUT when cnt+1 == len_q. No accept: hold.
- OUT: `in_ready`=0, `out_valid`=1. On `out_ready`: go IDLE, drop `out_valid`. `out_data`/`out_ovf` stable while `out_valid & ~out_ready`.
- Arithmetic: all additions signed at ACC_W bits; `in_sum` sign-extended from N+1 bits.
- `out_ovf` = 1 when acc > 2^(N-1)-1 or acc < -2^(N-1), computed on the final acc; independent of the configuration macro.
- `frame_len` changes mid-frame are ignored (len_q used).
- `busy` = (state != IDLE).

## Timing
- Reset (while `rst`=1 and the cycle after edge): state IDLE, acc 0, cnt 0, len_q 0, `out_valid` 0, `out_data` 0, `out_ovf` 0, `busy` 0; `in_ready` forced 0 while `rst` high, 1 from the first cycle after release.
- `in_ready` and `out_valid` are decoded from registered state only; no combinational path from `in_valid` or `out_ready`.
- Latency: `out_valid` rises the cycle after the last sample of a frame is accepted.
- Throughput: one frame per len_q + 1 cycles minimum; no input accepted in OUT, including the cycle `out_ready` is sampled high.
- Reset mid-frame or in OUT: partial frame and pending result discarded; `out_valid` low next cycle.
- `out_data`/`out_ovf` registered on entry to OUT; hold their values after leaving OUT until the next frame's result.

## Configuration
- `SUM_ACCUM_SAT_EN` defined: `out_data` = 2^(N-1)-1 if acc above range, -2^(N-1) if below, else acc[N-1:0].
- Not defined: `out_data` = acc[N-1:0] (two's-complement wrap); `out_ovf` still reports out-of-range.

## Test plan
- N=8, frame_len=2, sums 8 then 2, `out_ready`=1 -> `out_data`=10, `out_ovf`=0, `out_valid` for one cycle, one cycle after second accept.
- frame_len=1, sum 128 (127+1) -> with macro `out_data`=127, `out_ovf`=1; without macro `out_data`=-128, `out_ovf`=1.
- frame_len=3, sums -30, -129, -20 -> total -179; with macro `out_data`=-128, `out_ovf`=1; without macro `out_data`=77, `out_ovf`=1.
- frame_len=1, sum -5, `out_ready` low 3 cycles -> `out_valid`=1, `out_data`=-5 stable, `in_ready`=0 throughout; IDLE the cycle after `out_ready`=1.
- frame_len=0, sum 7 -> treated as 1; `out_data`=7 next cycle. Then frame_len=4, 2 samples accepted, frame_len changed to 2 -> no output until 4th sample.
- frame_len=3, accept 2 samples, pulse `rst` -> `out_valid` stays 0, `busy`=0; new frame 1+1+1 -> `out_data`=3 (no residue from aborted frame).

Source files
------------

// File: rtl/sum_accum_sat.sv
// Frame accumulator for signed (N+1)-bit adder sums; emits N-bit result with overflow flag.
// Define SUM_ACCUM_SAT_EN to saturate out_data instead of two's-complement wrap.
module sum_accum_sat #(
  parameter int N     = 8,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [N:0]    in_sum,
  input  logic [LEN_W-1:0]     frame_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int ACC_W = N + 1 + LEN_W;
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, sum_ext;
  logic [LEN_W-1:0]         cnt_q, cnt_d, len_q, len_d, cnt_inc, len_sel;
  logic [N-1:0]             data_q, data_d, result;
  logic                     ovf_q, ovf_d;
  logic                     accept, above, below;

  assign sum_ext = {{LEN_W{in_sum[N]}}, in_sum};
  assign cnt_inc = cnt_q + 1'b1;
  assign len_sel = (frame_len == '0) ? LEN_W'(1) : frame_len;
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (len_sel == LEN_W'(1)) ? OUT : ACCUM;
      ACCUM:   if (accept && (cnt_inc == len_q)) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = ~rst & (state_q != OUT);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    if (accept && state_q == IDLE) begin
      acc_d = sum_ext;
      cnt_d = LEN_W'(1);
      len_d = len_sel;
    end else if (accept && state_q == ACCUM) begin
      acc_d = acc_q + sum_ext;
      cnt_d = cnt_inc;
    end
  end

  // Range check and reduction act on the final total, so results latch on OUT entry.
  always_comb begin
    above = (acc_d > MAX_V);
    below = (acc_d < MIN_V);
`ifdef SUM_ACCUM_SAT_EN
    if (above)      result = MAX_V[N-1:0];
    else if (below) result = MIN_V[N-1:0];
    else            result = acc_d[N-1:0];
`else
    result = acc_d[N-1:0];
`endif
    data_d = data_q;
    ovf_d  = ovf_q;
    if (state_d == OUT && state_q != OUT) begin
      data_d = result;
      ovf_d  = above | below;
    end
  end

  assign out_data = data_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_sum_accum_sat.sv
// Scoreboard bench for sum_accum_sat: directed frames, expected results queued, monitor compares.
module tb_sum_accum_sat;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [8:0] in_sum;
  logic [3:0]        frame_len;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_ovf;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  sum_accum_sat #(.N(8), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .frame_len (frame_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic signed [7:0] d, input logic o);
    exp_q.push_back({o, d});
  endtask

  task automatic send(input logic signed [8:0] s, input logic [3:0] len);
    int n;
    in_valid  = 1'b1;
    in_sum    = s;
    frame_len = len;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for sum %0d", s);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: data %0d ovf %0d", $signed(out_data), out_ovf);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; frame_len = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // frame of 2: 8 + 2
    push_exp(8'sd10, 1'b0);
    send(9'sd8, 4'd2);
    chk("busy_accum", {31'd0, busy}, 32'd1);
    send(9'sd2, 4'd2);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);

    // single 128
`ifdef SUM_ACCUM_SAT_EN
    push_exp(8'sd127, 1'b1);
`else
    push_exp(-8'sd128, 1'b1);
`endif
    send(9'sd128, 4'd1);

    // -30 -129 -20 = -179
`ifdef SUM_ACCUM_SAT_EN
    push_exp(-8'sd128, 1'b1);
`else
    push_exp(8'sd77, 1'b1);
`endif
    send(-9'sd30, 4'd3);
    send(-9'sd129, 4'd3);
    send(-9'sd20, 4'd3);

    // backpressure hold
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_exp(-8'sd5, 1'b0);
    send(-9'sd5, 4'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {24'd0, out_data}, {24'd0, 8'hFB});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_busy", {31'd0, busy}, 32'd0);
    chk("release_valid", {31'd0, out_valid}, 32'd0);

    // frame_len 0 treated as 1
    push_exp(8'sd7, 1'b0);
    send(9'sd7, 4'd0);
    chk("len0_valid", {31'd0, out_valid}, 32'd1);

    // mid-frame frame_len change ignored
    send(9'sd1, 4'd4);
    send(9'sd2, 4'd4);
    send(9'sd3, 4'd2);
    chk("lenchg_no_out", {31'd0, out_valid}, 32'd0);
    push_exp(8'sd10, 1'b0);
    send(9'sd4, 4'd2);
    chk("lenchg_out", {31'd0, out_valid}, 32'd1);

    // abort partial frame with reset
    send(9'sd5, 4'd3);
    send(9'sd6, 4'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_rel_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_rel_valid", {31'd0, out_valid}, 32'd0);
    push_exp(8'sd3, 1'b0);
    send(9'sd1, 4'd3);
    send(9'sd1, 4'd3);
    send(9'sd1, 4'd3);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
